// File: rtl/hiscore_ram_arbiter.sv
`default_nettype none
// ============================================================================
// hiscore_ram_arbiter
// Shares one game work-RAM port between the CPU and a hiscore engine.
// The CPU has priority. Optional macro HISCORE_ARB_STARVE_EN pauses the CPU
// after STARVE_MAX starved cycles, so that a waiting hiscore request is served.
// Revision: 1.0
// ============================================================================
module hiscore_ram_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_cs,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_pause,
    input  logic              hs_req,
    input  logic              hs_we,
    input  logic [ADDR_W-1:0] hs_addr,
    input  logic [DATA_W-1:0] hs_wdata,
    output logic              hs_ack,
    output logic [DATA_W-1:0] hs_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PAUSE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   hs_ack_q, hs_ack_d;
    logic   cpu_pause_q, cpu_pause_d;
    logic   w_grant_hs;

`ifdef HISCORE_ARB_STARVE_EN
    localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

    logic [3:0] starve_q, starve_d;
    logic [3:0] w_starve_inc;

    always_comb begin
        w_starve_inc = (starve_q == C_STARVE_MAX) ? starve_q : starve_q + 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // Starvation limit has no effect when the CPU can never be paused.
    logic [3:0] w_unused_starve_max;
    assign w_unused_starve_max = 4'(STARVE_MAX);
`endif

    // The hiscore engine only gets the port on a CPU-idle cycle or while the CPU is paused.
    always_comb begin
        w_grant_hs = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE:    w_grant_hs = hs_req && !cpu_cs;
                PAUSE:   w_grant_hs = hs_req;
                default: w_grant_hs = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
`ifdef HISCORE_ARB_STARVE_EN
        starve_d = starve_q;
`endif
        case (state_q)
            IDLE: begin
                if (w_grant_hs) begin
                    state_d = ACK;
                end
`ifdef HISCORE_ARB_STARVE_EN
                if (w_grant_hs || !hs_req) begin
                    starve_d = 4'd0;
                end else if (cpu_cs) begin
                    starve_d = w_starve_inc;
                    if (w_starve_inc == C_STARVE_MAX) begin
                        state_d = PAUSE;
                    end
                end
`endif
            end
            PAUSE:   state_d = w_grant_hs ? ACK : IDLE;
            default: state_d = IDLE;
        endcase
`ifdef HISCORE_ARB_STARVE_EN
        if (state_q != IDLE) begin
            starve_d = 4'd0;
        end
`endif
        hs_ack_d    = (state_d == ACK);
        cpu_pause_d = (state_d == PAUSE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            hs_ack_q    <= 1'b0;
            cpu_pause_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hs_ack_q    <= hs_ack_d;
            cpu_pause_q <= cpu_pause_d;
        end
    end

    always_comb begin
        if (w_grant_hs) begin
            ram_addr  = hs_addr;
            ram_we    = hs_we;
            ram_wdata = hs_wdata;
        end else begin
            ram_addr  = cpu_addr;
            ram_we    = cpu_we && cpu_cs && !cpu_pause_q;
            ram_wdata = cpu_wdata;
        end
    end

    assign cpu_pause = cpu_pause_q;
    assign hs_ack    = hs_ack_q;
    assign cpu_rdata = ram_rdata;
    assign hs_rdata  = ram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_hiscore_ram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_hiscore_ram_arbiter
// Directed and random bench for hiscore_ram_arbiter against a cycle model.
// Revision: 1.0
// ============================================================================
module tb_hiscore_ram_arbiter;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 8;
    localparam int STARVE_MAX = 15;
    localparam int DEPTH      = 1 << ADDR_W;
`ifdef HISCORE_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cpu_cs = 1'b0, cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_pause;
    logic              hs_req = 1'b0, hs_we = 1'b0;
    logic [ADDR_W-1:0] hs_addr = '0;
    logic [DATA_W-1:0] hs_wdata = '0;
    logic              hs_ack;
    logic [DATA_W-1:0] hs_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata = '0;

    always #5 clk = ~clk;

    hiscore_ram_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_cs    (cpu_cs),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_pause (cpu_pause),
        .hs_req    (hs_req),
        .hs_we     (hs_we),
        .hs_addr   (hs_addr),
        .hs_wdata  (hs_wdata),
        .hs_ack    (hs_ack),
        .hs_rdata  (hs_rdata),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Work RAM attached to the arbiter: synchronous, read-before-write.
    logic [DATA_W-1:0] ram_mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    // Reference model: who owns the port this cycle and what the engine is owed.
    bit                m_ack   = 1'b0;
    bit                m_pause = 1'b0;
    int                m_wait  = 0;
    logic [DATA_W-1:0] mm [0:DEPTH-1];
    logic [DATA_W-1:0] m_rd_exp = '0;
    bit                m_rd_chk = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_grant();
        return !reset && hs_req && !m_ack && (!cpu_cs || m_pause);
    endfunction

    task automatic check_model();
        bit g, ack_e, pause_e;
        g       = model_grant();
        ack_e   = m_ack && !reset;
        pause_e = m_pause && !reset;
        chk("ram_addr",  ram_addr,  g ? hs_addr : cpu_addr);
        chk("ram_we",    ram_we,    g ? hs_we : (cpu_we && cpu_cs && !pause_e));
        chk("ram_wdata", ram_wdata, g ? hs_wdata : cpu_wdata);
        chk("hs_ack",    hs_ack,    ack_e);
        chk("cpu_pause", cpu_pause, pause_e);
        chk("cpu_rdata", cpu_rdata, ram_rdata);
        chk("hs_rdata",  hs_rdata,  ram_rdata);
        if (ack_e && m_rd_chk) chk("hs_rdata_ack", hs_rdata, m_rd_exp);
    endtask

    task automatic update_model();
        bit                g, pause_e, we, starving;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        int                w;
        g       = model_grant();
        pause_e = m_pause && !reset;
        a       = g ? hs_addr : cpu_addr;
        d       = g ? hs_wdata : cpu_wdata;
        we      = g ? hs_we : (cpu_we && cpu_cs && !pause_e);
        if (g) begin
            m_rd_exp = mm[hs_addr];
            m_rd_chk = !hs_we;
        end
        if (we) mm[a] = d;
        if (reset) begin
            m_ack = 1'b0; m_pause = 1'b0; m_wait = 0;
        end else begin
            starving = !g && !m_ack && !m_pause && hs_req && cpu_cs;
            w        = starving ? ((m_wait + 1 > STARVE_MAX) ? STARVE_MAX : m_wait + 1) : 0;
            m_pause  = STARVE_EN && starving && (w >= STARVE_MAX);
            m_wait   = w;
            m_ack    = g;
        end
    endtask

    // Inputs change only at the falling edge; checks run just after it.
    task automatic tick();
        #1;
        check_model();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    int pause_at, ack_at, acks;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram_mem[i] = 8'(i) ^ 8'h3C;
            mm[i]      = 8'(i) ^ 8'h3C;
        end
        ram_mem[11] = 8'h10;
        mm[11]      = 8'h10;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_hs_ack", hs_ack, 0);
        chk("rst_cpu_pause", cpu_pause, 0);
        chk("rst_ram_we", ram_we, 0);
        tick(); tick();
        reset = 1'b0;

        // Hiscore write on an idle CPU cycle
        hs_req = 1; hs_we = 1; hs_addr = 10'h023; hs_wdata = 8'h5A;
        #1;
        chk("hsw_ram_we", ram_we, 1);
        chk("hsw_ram_addr", ram_addr, 10'h023);
        chk("hsw_ack_early", hs_ack, 0);
        tick();
        hs_req = 0;
        #1;
        chk("hsw_ack", hs_ack, 1);
        tick();
        chk("hsw_mem", ram_mem[10'h023], 8'h5A);

        // Hiscore read of a preloaded location
        hs_req = 1; hs_we = 0; hs_addr = 10'h00B;
        tick();
        hs_req = 0;
        #1;
        chk("hsr_ack", hs_ack, 1);
        chk("hsr_rdata", hs_rdata, 8'h10);
        tick();

        // Contention: CPU wins, hiscore served on the first free cycle
        cpu_cs = 1; cpu_we = 1; cpu_addr = 10'h100; cpu_wdata = 8'h77;
        hs_req = 1; hs_we = 0; hs_addr = 10'h00B;
        #1;
        chk("cont_ram_we", ram_we, 1);
        chk("cont_ram_addr", ram_addr, 10'h100);
        chk("cont_ram_wdata", ram_wdata, 8'h77);
        tick();
        cpu_cs = 0; cpu_we = 0;
        #1;
        chk("cont_hs_addr", ram_addr, 10'h00B);
        chk("cont_hs_we", ram_we, 0);
        tick();
        hs_req = 0;
        #1;
        chk("cont_ack", hs_ack, 1);
        tick();
        chk("cont_mem", ram_mem[10'h100], 8'h77);

        // Starvation: CPU busy every cycle while a hiscore write waits
        cpu_cs = 1; cpu_we = 0; cpu_addr = 10'h005;
        hs_req = 1; hs_we = 1; hs_addr = 10'h055; hs_wdata = 8'hA5;
        pause_at = -1; ack_at = -1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (cpu_pause && pause_at < 0) pause_at = i;
            if (hs_ack && ack_at < 0) ack_at = i;
            if (hs_ack) hs_req = 0;
            tick();
        end
        chk("starve_pause_cycle", pause_at, STARVE_EN ? STARVE_MAX : -1);
        chk("starve_ack_cycle", ack_at, STARVE_EN ? STARVE_MAX + 1 : -1);
        hs_req = 0;
        tick();

        // Reset while the CPU is paused for a pending request
        hs_req = 1; hs_we = 0; hs_addr = 10'h00B;
        for (int i = 0; i < STARVE_MAX; i++) tick();
        #1;
        chk("prerst_pause", cpu_pause, STARVE_EN);
        reset = 1; hs_req = 0;
        #1;
        chk("midrst_pause", cpu_pause, 0);
        chk("midrst_ack", hs_ack, 0);
        tick();
        reset = 0;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            acks += int'(hs_ack);
            tick();
        end
        chk("postrst_no_ack", acks, 0);

        // Request withdrawn while paused: no RAM write, no ack
        cpu_we = 1; cpu_addr = 10'h200; cpu_wdata = 8'h99;
        hs_req = 1; hs_we = 0; hs_addr = 10'h00B;
        for (int i = 0; i < STARVE_MAX; i++) tick();
        hs_req = 0;
        #1;
        chk("abort_ram_we", ram_we, !STARVE_EN);
        tick();
        #1;
        chk("abort_ack", hs_ack, 0);
        chk("abort_pause", cpu_pause, 0);
        tick();

        // Random traffic, alternating light and heavy CPU load
        for (int c = 0; c < 3000; c++) begin
            reset = 1'b0;
            if (hs_ack) begin
                hs_req = 0;
            end else if (!hs_req && $urandom_range(0, 3) == 0) begin
                hs_req   = 1;
                hs_we    = 1'($urandom);
                hs_addr  = ADDR_W'($urandom_range(0, 15));
                hs_wdata = DATA_W'($urandom);
            end else if (hs_req && cpu_pause && $urandom_range(0, 7) == 0) begin
                hs_req = 0;
            end
            if (((c / 300) % 2) == 1) cpu_cs = ($urandom_range(0, 15) != 0);
            else cpu_cs = 1'($urandom);
            cpu_we    = 1'($urandom);
            cpu_addr  = ADDR_W'($urandom_range(0, 15));
            cpu_wdata = DATA_W'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                reset  = 1'b1;
                hs_req = 1'b0;
            end
            tick();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hiscore_ram_arbiter.md
HISCORE_RAM_ARBITER -- requirements
Module: hiscore_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, game work-RAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL have parameter STARVE_MAX, default 15, cycles of pending hiscore request before CPU pause (1..15).
REQ-004 SHALL have ports:
clk  in  1  single clock; all state on rising edge
reset  in  1  asynchronous, active-high
cpu_cs  in  1  CPU RAM access this cycle
cpu_we  in  1  CPU write strobe
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  read data to CPU
cpu_pause  out  1  CPU stall request (registered)
hs_req  in  1  hiscore engine request, held until hs_ack
hs_we  in  1  hiscore write (1) / read (0)
hs_addr  in  ADDR_W  hiscore address
hs_wdata  in  DATA_W  hiscore write data
hs_ack  out  1  one-cycle completion pulse (registered)
hs_rdata  out  DATA_W  read data, valid while hs_ack=1
ram_addr  out  ADDR_W  to RAM port
ram_we  out  1  to RAM port
ram_wdata  out  DATA_W  to RAM port
ram_rdata  in  DATA_W  from RAM, synchronous read, 1-cycle latency

Function
REQ-005 SHALL implement states IDLE, PAUSE, ACK.
REQ-006 grant_hs (combinational) SHALL be 1 in IDLE when hs_req=1 and cpu_cs=0, and unconditionally in PAUSE when hs_req=1; 0 otherwise.
REQ-007 When grant_hs=1, ram_addr/ram_we/ram_wdata SHALL equal hs_addr/hs_we/hs_wdata; otherwise cpu_addr/(cpu_we&cpu_cs&~cpu_pause)/cpu_wdata.
REQ-008 cpu_rdata and hs_rdata SHALL both be combinational copies of ram_rdata.
REQ-009 IDLE -> ACK on grant_hs; IDLE -> PAUSE when starve counter reaches STARVE_MAX with hs_req=1; else stay IDLE.
REQ-010 PAUSE -> ACK on grant_hs; PAUSE -> IDLE if hs_req=0 (aborted request, no RAM access).
REQ-011 ACK -> IDLE unconditionally after one cycle; hs_ack=1 only in ACK; no hiscore grant in ACK; CPU owns port in ACK.
REQ-012 Latency: hs_ack SHALL assert exactly one cycle after the granting cycle, for both read and write; read data in ACK is RAM data at the granted address.
REQ-013 hs_req SHALL be sampled only while not in ACK; engine drops hs_req in ACK cycle; new request honoured from the following cycle.
REQ-014 Simultaneous cpu_cs=1 and hs_req=1 in IDLE: CPU wins.
REQ-015 cpu_pause SHALL be 1 exactly while in PAUSE; CPU accesses are ignored (no RAM write) while cpu_pause=1.
REQ-016 Starve counter (4 bits): cleared on any grant_hs and when hs_req=0; increments in IDLE each cycle hs_req=1 and cpu_cs=1; saturates at STARVE_MAX.

Reset
REQ-017 reset=1 SHALL force state IDLE, starve counter 0, cpu_pause 0, hs_ack 0 immediately and asynchronously.
REQ-018 Reset mid-transaction SHALL drop the pending hiscore request without ack; engine reissues after reset.
REQ-019 Combinational outputs during reset SHALL follow the CPU path (grant_hs=0).

Configuration
REQ-020 Macro HISCORE_ARB_STARVE_EN: defined -> starve counter, PAUSE state and cpu_pause per REQ-009..016.
REQ-021 Undefined -> no counter, PAUSE never entered, cpu_pause tied 0; hiscore waits indefinitely for cpu_cs=0 idle cycles.

Verification
REQ-022 cpu_cs=0, hs write addr 0x023 data 0x5A -> ram_we=1 same cycle at 0x023, hs_ack one cycle later, memory[0x023]=0x5A.
REQ-023 cpu_cs=0, hs read addr 0x00B (preloaded 0x10) -> hs_ack next cycle with hs_rdata=0x10.
REQ-024 cpu_cs=1 and hs_req=1 same cycle, CPU writes 0x77 to 0x100 -> RAM writes CPU data; hs granted first cycle cpu_cs=0.
REQ-025 STARVE_EN, cpu_cs held 1, hs_req held 1 -> after 15 cycles cpu_pause=1 one cycle, hs granted, hs_ack next cycle, counter 0; without macro no pause, no ack.
REQ-026 reset asserted during PAUSE -> cpu_pause=0 and state IDLE immediately, no hs_ack ever for that request.
REQ-027 hs_req dropped while in PAUSE -> return IDLE, ram_we=0, no hs_ack.
